// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the accumulator CPU control unit: state encoding,
// opcode constants, bus source codes and load-strobe bit positions.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH_AR  = 4'd0,
        ST_FETCH_IR  = 4'd1,
        ST_DECODE    = 4'd2,
        ST_INDIRECT  = 4'd3,
        ST_OPERAND   = 4'd4,
        ST_EXECUTE   = 4'd5,
        ST_WRITEBACK = 4'd6,
        ST_STORE     = 4'd7,
        ST_JUMP      = 4'd8,
        ST_HALT      = 4'd9,
        ST_FAULT     = 4'd10
    } state_e;

    localparam int OPC_STORE = 5;
    localparam int OPC_JMP   = 6;
    localparam int OPC_HALT  = 7;

    localparam int BUS_IDLE = 0;
    localparam int BUS_PC   = 2;
    localparam int BUS_AC   = 4;
    localparam int BUS_IR   = 5;
    localparam int BUS_AR   = 6;
    localparam int BUS_MEM  = 7;

    localparam int LD_AR = 0;
    localparam int LD_PC = 1;
    localparam int LD_DR = 2;
    localparam int LD_AC = 3;
    localparam int LD_IR = 4;
    localparam int LD_TR = 5;

    function automatic logic is_mem_state(input state_e s);
        return (s == ST_FETCH_IR) || (s == ST_INDIRECT) ||
               (s == ST_OPERAND)  || (s == ST_STORE);
    endfunction

endpackage

// File: rtl/seq_control_unit.sv
// Microsequenced control unit for the accumulator CPU: fetch/decode/execute FSM
// with memory wait-state handshake, indirect addressing, JMP/HALT and timeout fault.
//
// state     | meaning
// FETCH_AR  | PC -> AR
// FETCH_IR  | read instruction, load IR, bump PC
// DECODE    | latch opcode, IR address field -> AR, branch
// INDIRECT  | read effective address into AR
// OPERAND   | read operand into DR
// EXECUTE   | ALU evaluates latched opcode
// WRITEBACK | ALU result -> AC, instruction done
// STORE     | write AC to memory
// JUMP      | AR -> PC
// HALT      | idle until resume
// FAULT     | memory timeout, sticky until reset
module seq_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int IR_W    = 8,
    parameter int OPC_W   = 3,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IR_W-1:0]  ir,
    input  logic             mem_ready,
    input  logic             resume,
    output logic [5:0]       load_en,
    output logic             inc_pc,
    output logic             mem_read,
    output logic             mem_write,
    output logic [SEL_W-1:0] bus_sel,
    output logic             alu_enable,
    output logic [OPC_W-1:0] alu_mode,
    output logic             instr_done,
    output logic             halted,
    output logic             fault
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e             r_state;
    logic [OPC_W-1:0]   r_opc;
    logic [CNT_W-1:0]   r_wait_cnt;

    state_e             w_next;
    logic [OPC_W-1:0]   w_ir_opc;
    logic               w_ir_ind;
    logic               w_mem_state;
    logic               w_timeout;
    logic               w_unused_ir;

    logic [5:0]         w_load_en;
    logic               w_inc_pc;
    logic               w_mem_read;
    logic               w_mem_write;
    logic [SEL_W-1:0]   w_bus_sel;
    logic               w_alu_enable;
    logic [OPC_W-1:0]   w_alu_mode;
    logic               w_instr_done;
    logic               w_halted;
    logic               w_fault;

    // The indirect flag only steers the DECODE branch, so it is consumed directly from ir.
    assign w_ir_opc    = ir[IR_W-2 -: OPC_W];
    assign w_ir_ind    = ir[IR_W-1];
    assign w_unused_ir = ^ir[IR_W-OPC_W-2:0];

    assign w_mem_state = is_mem_state(r_state);
    assign w_timeout   = w_mem_state && !mem_ready && (r_wait_cnt == CNT_LAST);

    function automatic state_e f_dispatch(input logic [OPC_W-1:0] opc);
        if (opc == OPC_W'(OPC_STORE))
            return ST_STORE;
        else if (opc == OPC_W'(OPC_JMP))
            return ST_JUMP;
        else
            return ST_OPERAND;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FETCH_AR;
            r_opc      <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE)
                r_opc <= w_ir_opc;
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if (w_mem_state && !mem_ready)
                r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_load_en    = '0;
        w_inc_pc     = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_bus_sel    = SEL_W'(BUS_IDLE);
        w_alu_enable = 1'b0;
        w_alu_mode   = '0;
        w_instr_done = 1'b0;
        w_halted     = 1'b0;
        w_fault      = 1'b0;
        case (r_state)
            ST_FETCH_AR: begin
                w_bus_sel        = SEL_W'(BUS_PC);
                w_load_en[LD_AR] = 1'b1;
                w_next           = ST_FETCH_IR;
            end
            ST_FETCH_IR: begin
                w_bus_sel  = SEL_W'(BUS_MEM);
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_load_en[LD_IR] = 1'b1;
                    w_inc_pc         = 1'b1;
                    w_next           = ST_DECODE;
                end else if (w_timeout) begin
                    w_next = ST_FAULT;
                end
            end
            ST_DECODE: begin
                w_bus_sel        = SEL_W'(BUS_IR);
                w_load_en[LD_AR] = 1'b1;
                if (w_ir_opc == OPC_W'(OPC_HALT)) begin
                    w_instr_done = 1'b1;
                    w_next       = ST_HALT;
                end else if (w_ir_ind) begin
                    w_next = ST_INDIRECT;
                end else begin
                    w_next = f_dispatch(w_ir_opc);
                end
            end
            ST_INDIRECT: begin
                w_bus_sel  = SEL_W'(BUS_MEM);
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_load_en[LD_AR] = 1'b1;
                    w_next           = f_dispatch(r_opc);
                end else if (w_timeout) begin
                    w_next = ST_FAULT;
                end
            end
            ST_OPERAND: begin
                w_bus_sel  = SEL_W'(BUS_MEM);
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_load_en[LD_DR] = 1'b1;
                    w_next           = ST_EXECUTE;
                end else if (w_timeout) begin
                    w_next = ST_FAULT;
                end
            end
            ST_EXECUTE: begin
                w_alu_enable = 1'b1;
                w_alu_mode   = r_opc;
                w_next       = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                w_load_en[LD_AC] = 1'b1;
                w_instr_done     = 1'b1;
                w_next           = ST_FETCH_AR;
            end
            ST_STORE: begin
                w_bus_sel   = SEL_W'(BUS_AC);
                w_mem_write = 1'b1;
                if (mem_ready) begin
                    w_instr_done = 1'b1;
                    w_next       = ST_FETCH_AR;
                end else if (w_timeout) begin
                    w_next = ST_FAULT;
                end
            end
            ST_JUMP: begin
                w_bus_sel        = SEL_W'(BUS_AR);
                w_load_en[LD_PC] = 1'b1;
                w_instr_done     = 1'b1;
                w_next           = ST_FETCH_AR;
            end
            ST_HALT: begin
                w_halted = 1'b1;
                if (resume)
                    w_next = ST_FETCH_AR;
            end
            ST_FAULT: begin
                w_fault = 1'b1;
            end
            default: begin
                w_next = ST_FETCH_AR;
            end
        endcase
    end

    // Gate with rst_n so nothing strobes while reset is held, even though the
    // reset state itself (FETCH_AR) would otherwise decode to PC -> AR.
    assign load_en    = rst_n ? w_load_en    : '0;
    assign inc_pc     = rst_n & w_inc_pc;
    assign mem_read   = rst_n & w_mem_read;
    assign mem_write  = rst_n & w_mem_write;
    assign bus_sel    = rst_n ? w_bus_sel    : '0;
    assign alu_enable = rst_n & w_alu_enable;
    assign alu_mode   = rst_n ? w_alu_mode   : '0;
    assign instr_done = rst_n & w_instr_done;
    assign halted     = rst_n & w_halted;
    assign fault      = rst_n & w_fault;

endmodule

// File: tb/tb_seq_control_unit.sv
// Self-checking bench for seq_control_unit: directed table, hand-written corner
// sequences and random instructions against an instruction-level reference model.
module tb_seq_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ir;
    logic       mem_ready;
    logic       resume;
    logic [5:0] load_en;
    logic       inc_pc;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] bus_sel;
    logic       alu_enable;
    logic [2:0] alu_mode;
    logic       instr_done;
    logic       halted;
    logic       fault;
    logic [18:0] w_all;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_control_unit #(.IR_W(8), .OPC_W(3), .SEL_W(3), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .mem_ready(mem_ready), .resume(resume),
        .load_en(load_en), .inc_pc(inc_pc), .mem_read(mem_read), .mem_write(mem_write),
        .bus_sel(bus_sel), .alu_enable(alu_enable), .alu_mode(alu_mode),
        .instr_done(instr_done), .halted(halted), .fault(fault)
    );

    assign w_all = {load_en, inc_pc, mem_read, mem_write, bus_sel, alu_enable,
                    alu_mode, instr_done, halted, fault};

    typedef struct {
        logic [7:0] ir;
        int w0, w1, w2;
        int cyc, nld, rdc, wrc, mode;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting at the FETCH_AR cycle; waits[] are consumed per memory access in order.
    task automatic run_instr(input logic [7:0] ir_v, input int w0, input int w1, input int w2,
                             output int cyc, output logic [47:0] sig, output int nld,
                             output int rdc, output int wrc, output int mode);
        int  w[3];
        int  acc;
        int  wleft;
        bit  done;
        w[0] = w0; w[1] = w1; w[2] = w2;
        acc = 0; wleft = w[0]; done = 1'b0;
        cyc = 0; sig = '0; nld = 0; rdc = 0; wrc = 0; mode = -1;
        ir = ir_v;
        while (!done && cyc < 60) begin
            cyc++;
            if (mem_read || mem_write) begin
                if (wleft > 0) begin
                    mem_ready = 1'b0;
                    wleft--;
                end else begin
                    mem_ready = 1'b1;
                    acc++;
                    wleft = (acc < 3) ? w[acc] : 0;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            resume = 1'($urandom_range(0, 1));
            #1;
            if (cyc == 1)
                chk("fetch_start", 64'({halted, bus_sel, load_en}), 64'({1'b0, 3'd2, 6'h01}));
            chk("rw_excl_flags", 64'({mem_read & mem_write, fault, halted}), 64'd0);
            if (mem_read) begin
                rdc++;
                chk("rd_bus", 64'(bus_sel), 64'd7);
            end
            if (mem_write) begin
                wrc++;
                chk("wr_bus", 64'(bus_sel), 64'd4);
            end
            if (load_en == 6'h02) chk("jmp_bus", 64'(bus_sel), 64'd6);
            if (inc_pc) chk("inc_pc_with_ir", 64'(load_en), 64'h10);
            if (load_en != 6'h00) begin
                nld++;
                sig = {sig[41:0], load_en};
            end
            if (alu_enable) mode = (mode == -1) ? int'(alu_mode) : -2;
            done = instr_done;
            next_cycle();
        end
        chk("instr_done_seen", 64'(done), 64'd1);
    endtask

    // Instruction-level expectation from the opcode rules and per-access wait counts.
    task automatic model(input logic [7:0] ir_v, input int w0, input int w1, input int w2,
                         output int cyc, output logic [47:0] sig, output int nld,
                         output int rdc, output int wrc, output int mode);
        int         opc;
        bit         halt;
        bit         ind;
        int         w[3];
        int         k;
        int         sumw;
        logic [5:0] q[$];
        w[0] = w0; w[1] = w1; w[2] = w2;
        opc  = int'(ir_v[6:4]);
        halt = (opc == 7);
        ind  = ir_v[7] && !halt;
        q    = '{6'h01, 6'h10, 6'h01};
        sumw = w[0];
        rdc  = w[0] + 1;
        k    = 1;
        if (ind) begin
            q.push_back(6'h01);
            sumw += w[1];
            rdc  += w[1] + 1;
            k     = 2;
        end
        wrc  = 0;
        mode = -1;
        if (halt) begin
            cyc = 3;
        end else if (opc == 6) begin
            cyc = 4;
            q.push_back(6'h02);
        end else if (opc == 5) begin
            cyc   = 4;
            sumw += w[k];
            wrc   = w[k] + 1;
        end else begin
            cyc   = 6;
            sumw += w[k];
            rdc  += w[k] + 1;
            q.push_back(6'h04);
            q.push_back(6'h08);
            mode  = opc;
        end
        cyc += int'(ind) + sumw;
        nld  = q.size();
        sig  = '0;
        foreach (q[i]) sig = {sig[41:0], q[i]};
    endtask

    task automatic do_halt(input int n);
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            resume    = 1'b0;
            #1;
            chk("halt_hold", 64'({halted, load_en, instr_done, mem_read}),
                64'({1'b1, 6'h00, 1'b0, 1'b0}));
            next_cycle();
        end
        resume = 1'b1;
        #1;
        chk("halt_resume_cycle", 64'(halted), 64'd1);
        next_cycle();
        resume = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[9];
        int         cyc, nld, rdc, wrc, mode;
        int         e_cyc, e_nld, e_rdc, e_wrc, e_mode;
        logic [47:0] sig, e_sig;
        logic [7:0] ir_r;
        int         w0, w1, w2;

        tbl[0] = '{8'h03, 0, 0, 0,  6, 5, 2, 0,  0};
        tbl[1] = '{8'hD0, 3, 3, 3, 14, 4, 8, 4, -1};
        tbl[2] = '{8'h60, 0, 0, 0,  4, 4, 1, 0, -1};
        tbl[3] = '{8'h2A, 1, 2, 0,  9, 5, 5, 0,  2};
        tbl[4] = '{8'hC4, 0, 1, 0,  8, 6, 4, 0,  4};
        tbl[5] = '{8'hE5, 2, 0, 0,  7, 5, 4, 0, -1};
        tbl[6] = '{8'h50, 0, 2, 0,  6, 3, 1, 3, -1};
        tbl[7] = '{8'hF0, 1, 0, 0,  4, 3, 2, 0, -1};
        tbl[8] = '{8'h1F, 0, 0, 0,  6, 5, 2, 0,  1};

        rst_n = 1'b0; ir = 8'h00; mem_ready = 1'b0; resume = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'(w_all), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_instr(tbl[i].ir, tbl[i].w0, tbl[i].w1, tbl[i].w2, cyc, sig, nld, rdc, wrc, mode);
            chk("tbl_cycles", 64'(cyc), 64'(tbl[i].cyc));
            chk("tbl_loads", 64'(nld), 64'(tbl[i].nld));
            chk("tbl_rd_cycles", 64'(rdc), 64'(tbl[i].rdc));
            chk("tbl_wr_cycles", 64'(wrc), 64'(tbl[i].wrc));
            chk("tbl_alu_mode", 64'(mode), 64'(tbl[i].mode));
            if (tbl[i].ir[6:4] == 3'd7) do_halt(3);
        end

        // Reset asserted while OPERAND is waiting on memory.
        ir = 8'h03; resume = 1'b0;
        mem_ready = 1'b0; #1; next_cycle();
        mem_ready = 1'b1; #1;
        chk("rst_seq_fetch_ir", 64'({mem_read, load_en}), 64'({1'b1, 6'h10}));
        next_cycle();
        mem_ready = 1'b0; #1; next_cycle();
        mem_ready = 1'b0; #1;
        chk("rst_seq_operand", 64'({mem_read, bus_sel}), 64'({1'b1, 3'd7}));
        rst_n = 1'b0; #1;
        chk("rst_mid_operand", 64'(w_all), 64'd0);
        next_cycle();
        chk("rst_held", 64'(w_all), 64'd0);
        rst_n = 1'b1;
        run_instr(8'h03, 0, 0, 0, cyc, sig, nld, rdc, wrc, mode);
        model(8'h03, 0, 0, 0, e_cyc, e_sig, e_nld, e_rdc, e_wrc, e_mode);
        chk("post_rst_cycles", 64'(cyc), 64'(e_cyc));
        chk("post_rst_loads", sig, e_sig);

        // Memory never answers in FETCH_IR: fault after TIMEOUT wait cycles.
        mem_ready = 1'b0; #1; next_cycle();
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b0; #1;
            chk("to_wait", 64'({fault, mem_read}), 64'({1'b0, 1'b1}));
            next_cycle();
        end
        mem_ready = 1'b1; #1;
        chk("to_fault", 64'(w_all), 64'd1);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            mem_ready = 1'($urandom_range(0, 1));
            resume    = 1'($urandom_range(0, 1));
            #1;
            chk("fault_sticky", 64'(w_all), 64'd1);
        end
        rst_n = 1'b0; #1;
        chk("fault_cleared", 64'(w_all), 64'd0);
        next_cycle();
        rst_n = 1'b1;

        for (int n = 0; n < 200; n++) begin
            ir_r = 8'($urandom);
            w0 = $urandom_range(0, 3);
            w1 = $urandom_range(0, 3);
            w2 = $urandom_range(0, 3);
            run_instr(ir_r, w0, w1, w2, cyc, sig, nld, rdc, wrc, mode);
            model(ir_r, w0, w1, w2, e_cyc, e_sig, e_nld, e_rdc, e_wrc, e_mode);
            chk("rnd_cycles", 64'(cyc), 64'(e_cyc));
            chk("rnd_load_seq", sig, e_sig);
            chk("rnd_load_cnt", 64'(nld), 64'(e_nld));
            chk("rnd_rd_cycles", 64'(rdc), 64'(e_rdc));
            chk("rnd_wr_cycles", 64'(wrc), 64'(e_wrc));
            chk("rnd_alu_mode", 64'(mode), 64'(e_mode));
            if (ir_r[6:4] == 3'd7) do_halt($urandom_range(1, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
